bus_transfer_controller: RTL

Sequencer for the shared 8-bit data bus between the buffered register file and its consumers. Accepts register-to-register move commands (one source, one or more destinations) into a 4-entry queue. Executes each move by driving exactly one register's output enable and then pulsing the destination latch lines. Guarantees no bus contention and a dead cycle between transfers.

---
 rtl/bus_transfer_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller
// Sequences register-to-register moves over a shared 8-bit bus. Commands are
// checked at accept, legal ones are held in a 4-entry in-order queue. Each
// move runs DRIVE -> LATCH -> RELEASE, which guarantees a single driver on
// the bus and a dead cycle before the next driver is enabled.
module bus_transfer_controller #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    req_src,
  input  logic [NUM_REGS-1:0] req_dst_mask,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic [NUM_REGS-1:0] reg_latch,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          queue_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_LATCH   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int DEPTH = 4;
  // Register count widened by one bit so an out-of-range select compares
  // correctly even when NUM_REGS == 2**SEL_W.
  localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

  logic [1:0]          state_reg, state_next;
  logic [SEL_W-1:0]    src_reg, src_next;
  logic [NUM_REGS-1:0] dst_reg, dst_next;

  // Queue storage is only four entries deep, so plain flops with a
  // combinational head read keep the pop-to-DRIVE timing at one edge.
  logic [SEL_W-1:0]    fifo_src [DEPTH];
  logic [NUM_REGS-1:0] fifo_dst [DEPTH];
  logic [1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [2:0]          count_reg;

  logic [NUM_REGS-1:0] req_src_oh;
  logic [NUM_REGS-1:0] src_next_oh;
  logic                req_illegal;
  logic                accept;
  logic                push;
  logic                pop;

  logic [NUM_REGS-1:0] reg_enable_reg;
  logic [NUM_REGS-1:0] reg_latch_reg;
  logic                done_reg;
  logic                err_reg;

  // One-hot decoders for the incoming source (legality) and the working
  // source (bus enable). An out-of-range select decodes to all zeros.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      assign req_src_oh[gi]  = (req_src  == SEL_W'(gi));
      assign src_next_oh[gi] = (src_next == SEL_W'(gi));
    end
  endgenerate

  assign req_ready   = (count_reg < 3'd4);
  assign accept      = req_valid && req_ready;
  assign req_illegal = ({1'b0, req_src} >= NUM_REGS_W) ||
                       (req_dst_mask == '0) ||
                       ((req_dst_mask & req_src_oh) != '0);
  assign push        = accept && !req_illegal;
  assign pop         = ((state_reg == ST_IDLE) || (state_reg == ST_RELEASE)) &&
                       (count_reg != 3'd0);

  // Next-state and working-register selection; a pop loads the queue head.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    case (state_reg)
      ST_IDLE, ST_RELEASE: begin
        if (pop) begin
          src_next   = fifo_src[rd_ptr_reg];
          dst_next   = fifo_dst[rd_ptr_reg];
          state_next = ST_DRIVE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRIVE: state_next = ST_LATCH;
      ST_LATCH: state_next = ST_RELEASE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM state and working registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
    end
  end

  // Queue payload write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr_reg] <= req_src;
      fifo_dst[wr_ptr_reg] <= req_dst_mask;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop leaves the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered bus controls, decoded from the state being entered so the
  // strobes line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_enable_reg <= '0;
      reg_latch_reg  <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      reg_enable_reg <= ((state_next == ST_DRIVE) || (state_next == ST_LATCH)) ?
                        src_next_oh : '0;
      reg_latch_reg  <= (state_next == ST_LATCH) ? dst_next : '0;
      done_reg       <= (state_next == ST_RELEASE);
      err_reg        <= accept && req_illegal;
    end
  end

  assign reg_enable  = reg_enable_reg;
  assign reg_latch   = reg_latch_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign busy        = (state_reg != ST_IDLE) || (count_reg != 3'd0);
  assign queue_count = count_reg;

endmodule
